io_input_conditioner: RTL and testbench
=======================================

IO_INPUT_CONDITIONER -- requirements
Module: io_input_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, the number of consecutive cycles a synchronized input must differ from its stable value before it is accepted (legal range 1 and up).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops per input bit (legal range 2 and up).
REQ-003 The block SHALL have parameter KEY_ACTIVE_LOW, default 1; when 1, raw_key bits are inverted so that a pressed key reads 1.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset: clock input 1 bit (all state updates on its rising edge), reset input 1 bit (synchronous, active-low).
REQ-005 Port raw_key, input, 4 bits: asynchronous push-button pins.
REQ-006 Port raw_sw, input, 10 bits: asynchronous slide-switch pins.
REQ-007 Port io_input_bus, output, 14 bits: debounced value, laid out as [13:10] KEY (1 = pressed) and [9:0] SW; it feeds the core io_input_bus.
REQ-008 Port key_pressed, output, 4 bits: one-cycle pulse per key on a debounced 0->1 transition.
REQ-009 Port key_released, output, 4 bits: one-cycle pulse per key on a debounced 1->0 transition.
REQ-010 Port key_event, output, 4 bits: sticky per-key press flag.
REQ-011 Port key_event_clear, input, 4 bits: per-key clear strobe for key_event.

Function
REQ-012 Polarity normalization SHALL be combinational and SHALL precede synchronization; each of the 14 normalized bits SHALL then pass through SYNC_STAGES flops.
REQ-013 Each bit SHALL own a stable register and a saturating-free counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-014 In any cycle where the synchronized bit equals its stable bit, the counter SHALL load 0.
REQ-015 In a cycle where the synchronized bit differs from its stable bit and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-016 In a cycle where the synchronized bit differs and counter == DEBOUNCE_CYCLES-1, the stable bit SHALL take the synchronized value and the counter SHALL load 0; the counter SHALL never wrap.
REQ-017 io_input_bus SHALL be driven directly from the stable registers with no extra delay.
REQ-018 Latency: a raw change held steady SHALL appear on io_input_bus exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after it is set up, counting the first sampling edge as edge 1.
REQ-019 Any synchronized excursion shorter than DEBOUNCE_CYCLES cycles SHALL leave the stable bit and all pulses unchanged.
REQ-020 key_pressed[i] and key_released[i] SHALL be registered and asserted for exactly one cycle, namely the cycle in which stable KEY bit i first shows its new value.
REQ-021 key_event[i] SHALL set on key_pressed[i] and SHALL clear on key_event_clear[i]; when both occur in the same cycle, set SHALL win; clearing an already-clear flag SHALL have no effect.
REQ-022 The SW bits SHALL generate no pulses or events.
REQ-023 All 14 bits SHALL be processed independently, and simultaneous transitions on multiple bits SHALL be handled in the same cycle.

Reset
REQ-024 While reset==0 at a rising edge, the synchronizer flops, stable registers, counters, key_pressed, key_released and key_event SHALL all load 0.
REQ-025 Reset asserted mid-debounce SHALL discard the partial count; after release, the full REQ-018 latency SHALL apply again.
REQ-026 No output SHALL pulse as a consequence of reset assertion or release alone, except for genuine 0->1 debounced transitions after release.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, KEY_ACTIVE_LOW=1)
REQ-027 Hold reset=0 for 3 cycles with raw_sw=10'h3FF and raw_key=4'h0, then release -> outputs are 0 during reset; io_input_bus=14'h3FFF at edge 6 after release; key_pressed=4'hF for one cycle; key_event=4'hF.
REQ-028 Drive raw_sw[0] 0->1 for 3 cycles, then 0 -> io_input_bus[0] stays 0 throughout.
REQ-029 Drive raw_key[2] 1->0 and hold -> io_input_bus[12]=1 at edge 6, key_pressed=4'b0100 for exactly one cycle, and key_event[2]=1 held until key_event_clear[2]; on release, key_released=4'b0100 for one cycle.
REQ-030 Assert key_event_clear[1] in the same cycle key_pressed[1] asserts -> key_event[1]=1 afterward.
REQ-031 Toggle raw_key[0] every cycle for 10 cycles, then hold pressed -> exactly one key_pressed[0] pulse, occurring 6 edges after the final toggle.
REQ-032 With raw_sw[5] counter at 2, pulse reset=0 for one cycle -> io_input_bus=0, and bit 5 rises exactly 6 edges after reset release.

Source files
------------

// File: rtl/io_input_conditioner.sv
// Input conditioning for push-buttons and slide switches: polarity normalization,
// multi-flop synchronization, per-bit debounce, and key press/release/event tracking.
module io_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  raw_key,
    input  logic [9:0]  raw_sw,
    input  logic [3:0]  key_event_clear,
    output logic [13:0] io_input_bus,
    output logic [3:0]  key_pressed,
    output logic [3:0]  key_released,
    output logic [3:0]  key_event
);

    localparam int NB = 14;
    localparam int NK = 4;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NB-1:0]                  norm_s;
    logic [NB-1:0]                  sync_out_s;
    logic [SYNC_STAGES-1:0][NB-1:0] sync_q;
    logic [SYNC_STAGES-1:0][NB-1:0] sync_d;
    logic [NB-1:0]                  stable_q;
    logic [NB-1:0]                  stable_d;
    logic [NB-1:0][CW-1:0]          cnt_q;
    logic [NB-1:0][CW-1:0]          cnt_d;
    logic [NK-1:0]                  pressed_q;
    logic [NK-1:0]                  pressed_d;
    logic [NK-1:0]                  released_q;
    logic [NK-1:0]                  released_d;
    logic [NK-1:0]                  event_q;
    logic [NK-1:0]                  event_d;

    // Normalize key polarity ahead of the synchronizers so a pressed key reads 1
    always_comb begin
        norm_s = '0;
        if (KEY_ACTIVE_LOW) begin
            norm_s = {~raw_key, raw_sw};
        end else begin
            norm_s = {raw_key, raw_sw};
        end
    end

    // Synchronizer shift chain next state
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = norm_s;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    assign sync_out_s = sync_q[SYNC_STAGES-1];

    // Per-bit debounce: count consecutive disagreeing cycles, accept on the last one
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < NB; i++) begin
            if (sync_out_s[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync_out_s[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Key edge pulses line up with the stable update; sticky flags give set priority
    always_comb begin
        pressed_d  = stable_d[NB-1 -: NK] & ~stable_q[NB-1 -: NK];
        released_d = ~stable_d[NB-1 -: NK] & stable_q[NB-1 -: NK];
        event_d    = (event_q & ~key_event_clear) | pressed_q;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q     <= '0;
            stable_q   <= '0;
            cnt_q      <= '0;
            pressed_q  <= '0;
            released_q <= '0;
            event_q    <= '0;
        end else begin
            sync_q     <= sync_d;
            stable_q   <= stable_d;
            cnt_q      <= cnt_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            event_q    <= event_d;
        end
    end

    assign io_input_bus = stable_q;
    assign key_pressed  = pressed_q;
    assign key_released = released_q;
    assign key_event    = event_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2, active-low keys.
module tb_io_input_conditioner;

    logic        clk;
    logic        rst_n;
    logic [3:0]  raw_key;
    logic [9:0]  raw_sw;
    logic [3:0]  key_event_clear;
    logic [13:0] io_input_bus;
    logic [3:0]  key_pressed;
    logic [3:0]  key_released;
    logic [3:0]  key_event;

    int checks = 0;
    int errors = 0;

    io_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES(2),
        .KEY_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .raw_key(raw_key),
        .raw_sw(raw_sw),
        .key_event_clear(key_event_clear),
        .io_input_bus(io_input_bus),
        .key_pressed(key_pressed),
        .key_released(key_released),
        .key_event(key_event)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        raw_sw = 10'h3FF;
        raw_key = 4'h0;
        key_event_clear = 4'h0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({io_input_bus, key_pressed, key_released, key_event} !== 26'h0) begin
                errors++;
                $display("FAIL reset_outputs: got bus=%h kp=%h kr=%h ke=%h, expected all 0",
                         io_input_bus, key_pressed, key_released, key_event);
            end
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            checks++;
            if (io_input_bus !== ((e >= 6) ? 14'h3FFF : 14'h0000)) begin
                errors++;
                $display("FAIL reset_release_bus edge %0d: got %h expected %h", e, io_input_bus,
                         (e >= 6) ? 14'h3FFF : 14'h0000);
            end
            checks++;
            if (key_pressed !== ((e == 6) ? 4'hF : 4'h0)) begin
                errors++;
                $display("FAIL reset_release_pressed edge %0d: got %h expected %h", e, key_pressed,
                         (e == 6) ? 4'hF : 4'h0);
            end
        end
        checks++;
        if (key_event !== 4'hF) begin
            errors++;
            $display("FAIL reset_release_event: got %h expected f", key_event);
        end
        key_event_clear = 4'hF;
        step();
        key_event_clear = 4'h0;
        checks++;
        if (key_event !== 4'h0) begin
            errors++;
            $display("FAIL event_clear_all: got %h expected 0", key_event);
        end
    endtask

    task automatic test_release_all();
        raw_sw = 10'h000;
        raw_key = 4'hF;
        for (int e = 1; e <= 7; e++) begin
            step();
            checks++;
            if (io_input_bus !== ((e >= 6) ? 14'h0000 : 14'h3FFF)) begin
                errors++;
                $display("FAIL release_all_bus edge %0d: got %h expected %h", e, io_input_bus,
                         (e >= 6) ? 14'h0000 : 14'h3FFF);
            end
            checks++;
            if (key_released !== ((e == 6) ? 4'hF : 4'h0) || key_pressed !== 4'h0) begin
                errors++;
                $display("FAIL release_all_pulses edge %0d: got kr=%h kp=%h expected kr=%h kp=0", e,
                         key_released, key_pressed, (e == 6) ? 4'hF : 4'h0);
            end
        end
    endtask

    task automatic test_sw_glitch();
        raw_sw[0] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            if (c == 2) raw_sw[0] = 1'b0;
            checks++;
            if (io_input_bus !== 14'h0000) begin
                errors++;
                $display("FAIL sw_glitch cycle %0d: got %h expected 0", c, io_input_bus);
            end
        end
    endtask

    task automatic test_key_press();
        raw_key[2] = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step();
            checks++;
            if (io_input_bus !== ((e >= 6) ? 14'h1000 : 14'h0000) ||
                key_pressed !== ((e == 6) ? 4'b0100 : 4'b0000) ||
                key_event !== ((e >= 7) ? 4'b0100 : 4'b0000)) begin
                errors++;
                $display("FAIL key2_press edge %0d: got bus=%h kp=%b ke=%b", e, io_input_bus,
                         key_pressed, key_event);
            end
        end
        for (int c = 0; c < 3; c++) step();
        checks++;
        if (key_event !== 4'b0100 || key_pressed !== 4'b0000) begin
            errors++;
            $display("FAIL key2_event_hold: got ke=%b kp=%b expected ke=0100 kp=0000", key_event, key_pressed);
        end
        key_event_clear = 4'b0100;
        step();
        key_event_clear = 4'b0000;
        checks++;
        if (key_event !== 4'b0000) begin
            errors++;
            $display("FAIL key2_event_clear: got %b expected 0000", key_event);
        end
        raw_key[2] = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            checks++;
            if (io_input_bus !== ((e >= 6) ? 14'h0000 : 14'h1000) ||
                key_released !== ((e == 6) ? 4'b0100 : 4'b0000) ||
                key_event !== 4'b0000) begin
                errors++;
                $display("FAIL key2_release edge %0d: got bus=%h kr=%b ke=%b", e, io_input_bus,
                         key_released, key_event);
            end
        end
    endtask

    task automatic test_clear_collision();
        raw_key[1] = 1'b0;
        for (int e = 1; e <= 6; e++) step();
        checks++;
        if (key_pressed !== 4'b0010) begin
            errors++;
            $display("FAIL key1_press: got %b expected 0010", key_pressed);
        end
        key_event_clear = 4'b0010;
        step();
        key_event_clear = 4'b0000;
        checks++;
        if (key_event !== 4'b0010) begin
            errors++;
            $display("FAIL set_beats_clear: got %b expected 0010", key_event);
        end
        step();
        checks++;
        if (key_event !== 4'b0010 || key_pressed !== 4'b0000) begin
            errors++;
            $display("FAIL set_beats_clear_hold: got ke=%b kp=%b", key_event, key_pressed);
        end
        raw_key[1] = 1'b1;
        for (int c = 0; c < 8; c++) step();
        key_event_clear = 4'hF;
        step();
        key_event_clear = 4'h0;
    endtask

    task automatic test_toggle();
        int pulses;
        pulses = 0;
        for (int i = 0; i <= 10; i++) begin
            raw_key[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
            if (i < 10) begin
                step();
                if (key_pressed[0]) pulses++;
                checks++;
                if (key_pressed[0] !== 1'b0 || io_input_bus[13:10] !== 4'h0) begin
                    errors++;
                    $display("FAIL toggle_bounce toggle %0d: got kp0=%b bus_key=%h expected 0", i,
                             key_pressed[0], io_input_bus[13:10]);
                end
            end
        end
        for (int e = 1; e <= 7; e++) begin
            step();
            if (key_pressed[0]) pulses++;
            checks++;
            if (key_pressed !== ((e == 6) ? 4'b0001 : 4'b0000)) begin
                errors++;
                $display("FAIL toggle_settle edge %0d: got %b expected %b", e, key_pressed,
                         (e == 6) ? 4'b0001 : 4'b0000);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL toggle_pulse_count: got %0d expected 1", pulses);
        end
        raw_key[0] = 1'b1;
        for (int c = 0; c < 8; c++) step();
        checks++;
        if (key_event !== 4'b0001 || io_input_bus !== 14'h0000) begin
            errors++;
            $display("FAIL toggle_final_state: got ke=%b bus=%h expected ke=0001 bus=0", key_event, io_input_bus);
        end
    endtask

    task automatic test_reset_mid();
        raw_sw[5] = 1'b1;
        for (int c = 0; c < 4; c++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (io_input_bus !== 14'h0000 || key_event !== 4'h0 || key_pressed !== 4'h0) begin
            errors++;
            $display("FAIL mid_reset_clear: got bus=%h ke=%h kp=%h expected all 0", io_input_bus,
                     key_event, key_pressed);
        end
        for (int e = 1; e <= 7; e++) begin
            step();
            checks++;
            if (io_input_bus !== ((e >= 6) ? 14'h0020 : 14'h0000) ||
                key_pressed !== 4'h0 || key_released !== 4'h0) begin
                errors++;
                $display("FAIL mid_reset_latency edge %0d: got bus=%h kp=%h kr=%h expected bus=%h", e,
                         io_input_bus, key_pressed, key_released, (e >= 6) ? 14'h0020 : 14'h0000);
            end
        end
    endtask

    initial begin
        test_reset();
        test_release_all();
        test_sw_glitch();
        test_key_press();
        test_clear_collision();
        test_toggle();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
